// File: rtl/input_conditioner.sv
// Board-pin front end: per-bit synchroniser and debouncer for switches and keys,
// plus one-cycle press/release strobes derived from the debounced key levels.
module input_conditioner #(
  parameter int N_SW            = 10,
  parameter int N_KEY           = 2,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_SW-1:0]  switch,
  input  logic [N_KEY-1:0] key,
  output logic [N_SW-1:0]  switch_clean,
  output logic [N_KEY-1:0] key_clean,
  output logic [N_KEY-1:0] key_press,
  output logic [N_KEY-1:0] key_release
);

  localparam int N  = N_SW + N_KEY;
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  // Keys are active-low, so their idle (reset) level is 1; switches idle at 0.
  localparam logic [N-1:0]  RST_VAL  = {{N_KEY{1'b1}}, {N_SW{1'b0}}};
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [N-1:0]     sync_q [SYNC_STAGES];
  logic [N-1:0]     s;
  logic [N-1:0]     stable_q, stable_d;
  logic [CW-1:0]    cnt_q [N];
  logic [CW-1:0]    cnt_d [N];
  logic [N_KEY-1:0] press_q, press_d;
  logic [N_KEY-1:0] release_q, release_d;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned k = 0; k < SYNC_STAGES; k++) sync_q[k] <= RST_VAL;
      for (int unsigned i = 0; i < N; i++) cnt_q[i] <= '0;
      stable_q  <= RST_VAL;
      press_q   <= '0;
      release_q <= '0;
    end else begin
      sync_q[0] <= {key, switch};
      for (int unsigned k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      for (int unsigned i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
      stable_q  <= stable_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  // Counter runs only while the synchronised level disagrees with the stable
  // level; any agreement clears it, so a glitch never accumulates.
  always_comb begin
    stable_d = stable_q;
    for (int unsigned i = 0; i < N; i++) begin
      cnt_d[i] = '0;
      if (s[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = s[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Strobes register alongside the level, so they coincide with the new key_clean.
  always_comb begin
    press_d   = stable_q[N-1:N_SW] & ~stable_d[N-1:N_SW];
    release_d = ~stable_q[N-1:N_SW] & stable_d[N-1:N_SW];
  end

  assign switch_clean = stable_q[N_SW-1:0];
  assign key_clean    = stable_q[N-1:N_SW];
  assign key_press    = press_q;
  assign key_release  = release_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner: directed vector table, hand-written
// multi-cycle sequences, and randomized stimulus against a sample-history model.
module tb_input_conditioner;

  localparam int NSW = 10;
  localparam int NK  = 2;
  localparam int N   = NSW + NK;
  localparam int S   = 2;
  localparam int D   = 4;
  localparam logic [N-1:0] RST_VAL = {{NK{1'b1}}, {NSW{1'b0}}};

  logic           clk;
  logic           reset_n;
  logic [NSW-1:0] switch;
  logic [NK-1:0]  key;
  logic [NSW-1:0] switch_clean;
  logic [NK-1:0]  key_clean;
  logic [NK-1:0]  key_press;
  logic [NK-1:0]  key_release;

  input_conditioner #(
    .N_SW(NSW), .N_KEY(NK), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk(clk), .reset_n(reset_n), .switch(switch), .key(key),
    .switch_clean(switch_clean), .key_clean(key_clean),
    .key_press(key_press), .key_release(key_release)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Reference model: an output bit takes a new value once the last D synchronised
  // samples (raw samples delayed by S edges) all agree on a value differing from it.
  logic [N-1:0]  hist [$];
  logic [N-1:0]  mq;
  logic [NK-1:0] m_press, m_rel;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    hist.delete();
    for (int k = 0; k < S + D; k++) hist.push_back(RST_VAL);
    mq      = RST_VAL;
    m_press = '0;
    m_rel   = '0;
  endtask

  task automatic model_step(input logic [N-1:0] raw);
    int  base;
    logic v, same;
    base    = hist.size() - S;
    m_press = '0;
    m_rel   = '0;
    for (int i = 0; i < N; i++) begin
      v    = hist[base][i];
      same = 1'b1;
      for (int j = 0; j < D; j++) if (hist[base-j][i] != v) same = 1'b0;
      if (same && v != mq[i]) begin
        mq[i] = v;
        if (i >= NSW) begin
          if (v) m_rel[i-NSW] = 1'b1;
          else   m_press[i-NSW] = 1'b1;
        end
      end
    end
    hist.push_back(raw);
    while (hist.size() > S + D) void'(hist.pop_front());
  endtask

  task automatic cmp_model();
    chk("model_switch_clean", 32'(switch_clean), 32'(mq[NSW-1:0]));
    chk("model_key_clean",    32'(key_clean),    32'(mq[N-1:NSW]));
    chk("model_key_press",    32'(key_press),    32'(m_press));
    chk("model_key_release",  32'(key_release),  32'(m_rel));
    chk("strobe_overlap",     32'(key_press & key_release), 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset_n) model_reset();
    else          model_step({key, switch});
    #1;
    cmp_model();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic assert_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("async_rst_sc", 32'(switch_clean), 32'd0);
    chk("async_rst_kc", 32'(key_clean),    32'h3);
    chk("async_rst_pr", 32'(key_press),    32'd0);
    chk("async_rst_rl", 32'(key_release),  32'd0);
  endtask

  typedef struct {
    logic [NSW-1:0] sw;
    logic [NK-1:0]  k;
    int             cyc;
    logic [NSW-1:0] e_sc;
    logic [NK-1:0]  e_kc;
    logic [NK-1:0]  e_pr;
    logic [NK-1:0]  e_rl;
  } vec_t;

  vec_t vecs [12];
  int   npress;

  initial begin
    vecs[0]  = '{10'h0FF, 2'b11, 5, 10'h000, 2'b11, 2'b00, 2'b00};
    vecs[1]  = '{10'h0FF, 2'b11, 1, 10'h0FF, 2'b11, 2'b00, 2'b00};
    vecs[2]  = '{10'h0FF, 2'b11, 2, 10'h0FF, 2'b11, 2'b00, 2'b00};
    vecs[3]  = '{10'h0FF, 2'b10, 6, 10'h0FF, 2'b10, 2'b01, 2'b00};
    vecs[4]  = '{10'h0FF, 2'b10, 1, 10'h0FF, 2'b10, 2'b00, 2'b00};
    vecs[5]  = '{10'h0FF, 2'b01, 6, 10'h0FF, 2'b01, 2'b10, 2'b01};
    vecs[6]  = '{10'h0FF, 2'b01, 1, 10'h0FF, 2'b01, 2'b00, 2'b00};
    vecs[7]  = '{10'h0FF, 2'b11, 6, 10'h0FF, 2'b11, 2'b00, 2'b10};
    vecs[8]  = '{10'h0F7, 2'b11, 3, 10'h0FF, 2'b11, 2'b00, 2'b00};
    vecs[9]  = '{10'h0FF, 2'b11, 8, 10'h0FF, 2'b11, 2'b00, 2'b00};
    vecs[10] = '{10'h0F7, 2'b11, 5, 10'h0FF, 2'b11, 2'b00, 2'b00};
    vecs[11] = '{10'h0F7, 2'b11, 1, 10'h0F7, 2'b11, 2'b00, 2'b00};

    // Reset held with all inputs active.
    reset_n = 1'b1;
    switch  = 10'h3FF;
    key     = 2'b00;
    #2;
    assert_reset();
    run(2);
    reset_n = 1'b1;
    run(5);
    chk("t1_edge5_sc", 32'(switch_clean), 32'h000);
    chk("t1_edge5_kc", 32'(key_clean),    32'h3);
    tick();
    chk("t1_edge6_sc", 32'(switch_clean), 32'h3FF);
    chk("t1_edge6_kc", 32'(key_clean),    32'h0);
    chk("t1_edge6_pr", 32'(key_press),    32'h3);
    tick();
    chk("t1_edge7_pr", 32'(key_press),    32'h0);

    switch = 10'h000;
    key    = 2'b11;
    run(8);

    for (int v = 0; v < 12; v++) begin
      switch = vecs[v].sw;
      key    = vecs[v].k;
      run(vecs[v].cyc);
      chk($sformatf("vec%0d_sc", v), 32'(switch_clean), 32'(vecs[v].e_sc));
      chk($sformatf("vec%0d_kc", v), 32'(key_clean),    32'(vecs[v].e_kc));
      chk($sformatf("vec%0d_pr", v), 32'(key_press),    32'(vecs[v].e_pr));
      chk($sformatf("vec%0d_rl", v), 32'(key_release),  32'(vecs[v].e_rl));
    end

    // Key bounce: toggles every 2 cycles, then settles low.
    npress = 0;
    for (int seg = 0; seg < 10; seg++) begin
      key[0] = (seg % 2 == 1);
      for (int c = 0; c < 2; c++) begin
        tick();
        chk("bounce_kc0", 32'(key_clean[0]), 32'd1);
        if (key_press[0]) npress++;
      end
    end
    key[0] = 1'b0;
    run(5);
    chk("bounce_edge5_kc0", 32'(key_clean[0]), 32'd1);
    tick();
    chk("bounce_edge6_kc0", 32'(key_clean[0]), 32'd0);
    if (key_press[0]) npress++;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (key_press[0]) npress++;
    end
    chk("bounce_press_count", 32'(npress), 32'd1);
    key = 2'b11;
    run(8);

    // Reset in the middle of a switch[9] count.
    switch = 10'h2F7;
    run(4);
    assert_reset();
    tick();
    reset_n = 1'b1;
    run(5);
    chk("rst_mid_edge5_sc", 32'(switch_clean), 32'h000);
    tick();
    chk("rst_mid_edge6_sc", 32'(switch_clean), 32'h2F7);

    // Randomized stimulus against the model.
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 6) == 0) begin
        if ($urandom_range(0, 2) == 0) key = NK'($urandom);
        else switch = switch ^ (NSW'(1) << $urandom_range(0, NSW - 1));
      end
      if ($urandom_range(0, 199) == 0) begin
        assert_reset();
        tick();
        reset_n = 1'b1;
      end
      tick();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
